// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, credit-limited imem requests, in-order instruction queue
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] branch_target
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    // address of the oldest in-flight request whose data will be kept
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [31:0]   tag_q  [DEPTH];
    logic [31:0]   tag_d  [DEPTH];
    logic [31:0]   instr_data_q, instr_data_d;
    logic [31:0]   instr_pc_q, instr_pc_d;

    logic          grant;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;
    logic [CW-1:0] remain;
    logic [31:0]   target_aligned;

    assign imem_addr   = pc_q;
    assign Instr       = instr_data_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (count_q != '0);

    // Request gating, next-state for PC, credit counters, queue and head output registers
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        resp_pc_d      = resp_pc_q;
        count_d        = count_q;
        outst_d        = outst_q;
        discard_d      = discard_q;
        head_d         = head_q;
        tail_d         = tail_q;
        data_d         = data_q;
        tag_d          = tag_q;
        instr_data_d   = instr_data_q;
        instr_pc_d     = instr_pc_q;
        target_aligned = branch_target & ~32'h3;

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = RUN;
        endcase

        credit_used = {1'b0, count_q} + {1'b0, outst_q};
        imem_req    = (state_q == RUN) && (credit_used < (CW+1)'(DEPTH)) && !PCSrc;
        grant       = imem_req && imem_gnt;
        pop         = instr_valid && instr_ready;
        push        = imem_rvalid && (discard_q == '0) && !PCSrc;
        remain      = count_q - CW'(pop);

        outst_d = outst_q + CW'(grant) - CW'(imem_rvalid);

        if (PCSrc) begin
            // every response still in flight after this edge belongs to the old path
            pc_d      = target_aligned;
            resp_pc_d = target_aligned;
            discard_d = outst_d;
            count_d   = '0;
            head_d    = '0;
            tail_d    = '0;
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_rvalid && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                data_d[tail_q] = imem_rdata;
                tag_d[tail_q]  = resp_pc_q;
                resp_pc_d      = resp_pc_q + 32'd4;
            end
            head_d  = head_q + PW'(pop);
            tail_d  = tail_q + PW'(push);
            count_d = remain + CW'(push);
            // Instr/instr_pc track the next head; they hold when the queue goes empty
            if (count_d != '0) begin
                if (remain == '0) begin
                    instr_data_d = imem_rdata;
                    instr_pc_d   = resp_pc_q;
                end else begin
                    instr_data_d = data_q[head_d];
                    instr_pc_d   = tag_q[head_d];
                end
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            count_q      <= '0;
            outst_q      <= '0;
            discard_q    <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            instr_data_q <= '0;
            instr_pc_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            count_q      <= count_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            instr_data_q <= instr_data_d;
            instr_pc_q   <= instr_pc_d;
            data_q       <= data_d;
            tag_q        <= tag_d;
        end
    end

    // A kept response must never land in a full queue unless the head leaves in the same cycle
    assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] branch_target;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Instr(Instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .PCSrc(PCSrc), .branch_target(branch_target)
    );

    typedef struct packed { logic [31:0] data; logic [31:0] pc; } ent_t;
    typedef struct packed { logic [31:0] pc; logic stale; } fly_t;
    typedef struct packed { logic [31:0] data; logic [31:0] due; } mem_t;
    typedef struct { logic req; logic [31:0] addr; logic valid; logic [31:0] pc; } vec_t;

    int checks = 0;
    int failures = 0;

    // reference model: queue of delivered words, list of in-flight fetches with a stale flag
    ent_t        m_q[$];
    fly_t        m_inf[$];
    logic [31:0] m_pc, m_last_instr, m_last_pc;
    logic        m_boot;

    // memory environment
    mem_t        mem[$];
    logic [31:0] mem_last_due;
    int          mem_lat = 1;
    logic [31:0] cyc = 0;
    int          n_grants;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_inf.delete();
        m_pc         = RESET_PC;
        m_last_instr = 32'h0;
        m_last_pc    = 32'h0;
        m_boot       = 1'b1;
        mem.delete();
        mem_last_due = cyc;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        instr_ready = 1'b0; PCSrc = 1'b0; branch_target = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", Instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_addr", imem_addr, RESET_PC);
        reset = 1'b1;
    endtask

    // one clock cycle, entered and left just after a falling edge
    task automatic cycle(input logic rdy, input logic ps, input logic [31:0] tgt, input logic g);
        logic        req_exp;
        logic [31:0] due;
        fly_t        r;
        s_valid = instr_valid; s_addr = imem_addr; s_pc = instr_pc; s_instr = Instr;
        chk("instr_valid", instr_valid, (m_q.size() != 0));
        chk("imem_addr", imem_addr, m_pc);
        chk("Instr", Instr, m_last_instr);
        chk("instr_pc", instr_pc, m_last_pc);
        instr_ready = rdy; PCSrc = ps; branch_target = tgt; imem_gnt = g;
        if (mem.size() > 0 && mem[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem[0].data;
            void'(mem.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        req_exp = !m_boot && (m_q.size() + m_inf.size() < DEPTH) && !ps;
        s_req = imem_req;
        chk("imem_req", imem_req, req_exp);
        if (imem_req && imem_gnt) begin
            due = cyc + mem_lat;
            if (due <= mem_last_due) due = mem_last_due + 1;
            mem.push_back('{data: word_of(imem_addr), due: due});
            mem_last_due = due;
            n_grants++;
        end
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (imem_rvalid && m_inf.size() > 0) begin
            r = m_inf.pop_front();
            if (!r.stale && !ps) m_q.push_back('{data: imem_rdata, pc: r.pc});
        end
        if (ps) begin
            m_q.delete();
            foreach (m_inf[i]) m_inf[i].stale = 1'b1;
            m_pc = tgt & ~32'h3;
        end else if (req_exp && g) begin
            m_inf.push_back('{pc: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (m_q.size() > 0) begin
            m_last_instr = m_q[0].data;
            m_last_pc    = m_q[0].pc;
        end
        m_boot = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        vec_t tbl[8];
        logic found;

        // 1-cycle memory, always granting, always ready
        tbl[0] = '{req: 1'b0, addr: 32'h00, valid: 1'b0, pc: 32'h00};
        tbl[1] = '{req: 1'b1, addr: 32'h00, valid: 1'b0, pc: 32'h00};
        tbl[2] = '{req: 1'b1, addr: 32'h04, valid: 1'b0, pc: 32'h00};
        tbl[3] = '{req: 1'b0, addr: 32'h08, valid: 1'b1, pc: 32'h00};
        tbl[4] = '{req: 1'b1, addr: 32'h08, valid: 1'b1, pc: 32'h04};
        tbl[5] = '{req: 1'b1, addr: 32'h0C, valid: 1'b0, pc: 32'h04};
        tbl[6] = '{req: 1'b0, addr: 32'h10, valid: 1'b1, pc: 32'h08};
        tbl[7] = '{req: 1'b1, addr: 32'h10, valid: 1'b1, pc: 32'h0C};

        @(negedge clk);
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
            chk("t1_req", s_req, tbl[i].req);
            chk("t1_addr", s_addr, tbl[i].addr);
            chk("t1_valid", s_valid, tbl[i].valid);
            chk("t1_pc", s_pc, tbl[i].pc);
        end

        // controller stalled: credit stops at DEPTH, nothing lost on resume
        do_reset();
        n_grants = 0;
        repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t2_grants", n_grants, 2);
        chk("t2_req_off", s_req, 0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t2_first_valid", s_valid, 1);
        chk("t2_first_pc", s_pc, 32'h0);
        chk("t2_first_instr", s_instr, word_of(32'h0));
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t2_second_pc", s_pc, 32'h4);
        chk("t2_second_instr", s_instr, word_of(32'h4));

        // redirect with two fetches in flight on a 3-cycle memory
        mem_lat = 3;
        do_reset();
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 32'h100, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
            found = s_valid;
        end
        chk("t3_found", found, 1);
        chk("t3_pc", s_pc, 32'h100);
        chk("t3_instr", s_instr, word_of(32'h100));

        // redirect coinciding with a response and a pop
        mem_lat = 1;
        do_reset();
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 32'h200, 1'b1);
        chk("t4_valid_at_redirect", s_valid, 1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t4_flushed", s_valid, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
            found = s_valid;
        end
        chk("t4_found", found, 1);
        chk("t4_pc", s_pc, 32'h200);

        // PC wrap, low target bits ignored
        do_reset();
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t5_addr_top", s_addr, 32'hFFFF_FFFC);
        chk("t5_req", s_req, 1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t5_addr_wrap", s_addr, 32'h0);

        // asynchronous reset mid-fetch
        mem_lat = 3;
        do_reset();
        repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t6_pre_valid", instr_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_req", imem_req, 0);
        chk("t6_valid", instr_valid, 0);
        chk("t6_instr", Instr, 0);
        chk("t6_pc", instr_pc, 0);
        chk("t6_addr", imem_addr, RESET_PC);
        imem_rvalid = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t6_boot_req", s_req, 0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t6_run_req", s_req, 1);
        chk("t6_run_addr", s_addr, RESET_PC);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            mem_lat = $urandom_range(1, 4);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
